// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// One shift-add (multiply) or restoring shift-subtract (divide) step per
// cycle on a shared 2*XLEN accumulator. Divide-by-zero and signed overflow
// finish in a single cycle.
//
// Ports:
//   clk, reset      : clock, synchronous active-high reset
//   start, funct3   : RV32M op request and its funct3 selector
//   op_a, op_b      : rs1 / rs2 operand values
//   flush           : abort current operation, block acceptance
//   stall           : freeze front of pipeline while the op is in flight
//   done, result    : one-cycle result-valid pulse and held result register
//   busy            : unit is iterating
module muldiv_unit #(
  parameter int XLEN = 32,
  parameter int ITER = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t            r_state, w_state_nxt;
  logic [2:0]        r_f3;
  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_b;
  logic [CW-1:0]     r_cnt;
  logic              r_neg;
  logic [XLEN-1:0]   r_result;

  // ---------------- acceptance-time decode ----------------
  logic            w_accept, w_sa, w_sb, w_neg, w_dz, w_ovf, w_triv;
  logic [XLEN-1:0] w_mag_a, w_mag_b, w_triv_res;

  assign w_accept = start & ~flush & (r_state != S_BUSY);
  // MULH, MULHSU, DIV, REM take |op_a|; MULH, DIV, REM take |op_b|.
  assign w_sa     = (funct3 == 3'b001) | (funct3 == 3'b010) |
                    (funct3 == 3'b100) | (funct3 == 3'b110);
  assign w_sb     = (funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110);
  assign w_mag_a  = (w_sa & op_a[XLEN-1]) ? -op_a : op_a;
  assign w_mag_b  = (w_sb & op_b[XLEN-1]) ? -op_b : op_b;

  always_comb begin
    w_neg = 1'b0;
    case (funct3)
      3'b001:  w_neg = op_a[XLEN-1] ^ op_b[XLEN-1]; // MULH
      3'b010:  w_neg = op_a[XLEN-1];                // MULHSU
      3'b100:  w_neg = op_a[XLEN-1] ^ op_b[XLEN-1]; // DIV quotient
      3'b110:  w_neg = op_a[XLEN-1];                // REM follows dividend
      default: w_neg = 1'b0;
    endcase
  end

  assign w_dz   = funct3[2] & (op_b == '0);
  assign w_ovf  = funct3[2] & ~funct3[0] &
                  (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (op_b == '1);
  assign w_triv = w_dz | w_ovf;

  always_comb begin
    w_triv_res = '0;
    if (w_dz)       w_triv_res = funct3[1] ? op_a : '1;
    else if (w_ovf) w_triv_res = funct3[1] ? '0 : op_a;
  end

  // ---------------- iteration step ----------------
  // Multiply: acc = {partial_hi, multiplier}; add multiplicand into the high
  // half when the multiplier LSB is set, then shift the whole thing right.
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_mul_nxt;
  assign w_sum     = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_b} : '0);
  assign w_mul_nxt = {w_sum, r_acc[XLEN-1:1]};

  // Divide: acc = {remainder, dividend/quotient}. The shifted remainder needs
  // XLEN+1 bits since it can reach 2*divisor-1.
  logic [XLEN:0]     w_rem_sh, w_diff;
  logic              w_ge;
  logic [2*XLEN-1:0] w_div_nxt;
  assign w_rem_sh  = r_acc[2*XLEN-1:XLEN-1];
  assign w_diff    = w_rem_sh - {1'b0, r_b};
  assign w_ge      = ~w_diff[XLEN];
  assign w_div_nxt = w_ge ? {w_diff[XLEN-1:0],   r_acc[XLEN-2:0], 1'b1}
                          : {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

  logic [2*XLEN-1:0] w_acc_nxt, w_prod_fin;
  logic [XLEN-1:0]   w_q, w_r, w_fin_res;
  assign w_acc_nxt  = r_f3[2] ? w_div_nxt : w_mul_nxt;
  assign w_prod_fin = r_neg ? -w_acc_nxt : w_acc_nxt;
  assign w_q        = w_acc_nxt[XLEN-1:0];
  assign w_r        = w_acc_nxt[2*XLEN-1:XLEN];

  always_comb begin
    w_fin_res = '0;
    case (r_f3)
      3'b000:                w_fin_res = w_acc_nxt[XLEN-1:0]; // low bits sign-independent
      3'b001, 3'b010, 3'b011: w_fin_res = w_prod_fin[2*XLEN-1:XLEN];
      3'b100, 3'b101:        w_fin_res = r_neg ? -w_q : w_q;
      default:               w_fin_res = r_neg ? -w_r : w_r;
    endcase
  end

  // ---------------- FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_triv ? S_DONE : S_BUSY;
      S_BUSY:  if (r_cnt == '0) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = w_accept ? (w_triv ? S_DONE : S_BUSY) : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
    if (flush) w_state_nxt = S_IDLE;
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      r_f3     <= '0;
      r_acc    <= '0;
      r_b      <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_result <= '0;
    end else if (!flush) begin
      if (w_accept) begin
        r_f3  <= funct3;
        r_acc <= {{XLEN{1'b0}}, w_mag_a};
        r_b   <= w_mag_b;
        r_cnt <= CW'(ITER - 1);
        r_neg <= w_neg;
        if (w_triv) r_result <= w_triv_res;
      end else if (r_state == S_BUSY) begin
        r_acc <= w_acc_nxt;
        r_cnt <= r_cnt - 1'b1;
        if (r_cnt == '0) r_result <= w_fin_res;
      end
    end
  end

  assign busy   = (r_state == S_BUSY);
  assign done   = (r_state == S_DONE);
  assign stall  = ~flush & (w_accept | busy);
  assign result = r_result;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit in the EX stage, next to the ALU.
- Accepts one operation at a time from the ID/EX latch and stalls the pipeline while it iterates.
- Hands one 32-bit result to EX/MEM writeback.
- One shift-add or shift-subtract step per cycle on a shared 64-bit accumulator.

Parameters:
XLEN, 32, operand/result width (only 32 is supported)
ITER, 32, iteration cycles per non-trivial operation (must equal XLEN)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  EX-stage instruction is RV32M (opcode OP, funct7=0000001)
funct3  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
op_a  input  32  rs1 value (after forwarding)
op_b  input  32  rs2 value (after forwarding)
flush  input  1  pipeline flush (taken branch/jump), aborts the current operation
stall  output  1  freeze PC, IF/ID and ID/EX
done  output  1  result valid this cycle; EX/MEM latches result
result  output  32  operation result
busy  output  1  state is BUSY

Behaviour:
- Clock and reset: one clock domain. reset is synchronous and active-high.
- Reset: state=IDLE. stall=0, done=0, busy=0, result=0. Accumulator, counter and sign flags cleared.
- Reset asserted mid-operation returns the unit to IDLE at the next edge; no done is produced.

- States:
  - IDLE: waiting for start.
  - BUSY: iterating.
  - DONE: result presented for exactly one cycle.

- Acceptance:
  - start is sampled when state is IDLE or DONE and flush=0. The acceptance cycle is cycle 0.
  - At the end of cycle 0, funct3 is latched. The magnitudes of op_a and op_b are latched according to signedness. The result sign flags are computed. The counter is loaded with ITER-1.
  - start while BUSY is ignored. The pipeline is already stalled, so the same instruction is re-presented and must not restart.

- Transitions:
  - IDLE -> BUSY on accepted start (normal case).
  - IDLE -> DONE directly on accepted start that is a trivial case: divide by zero or signed overflow.
  - BUSY -> DONE when counter==0 at the edge.
  - DONE -> IDLE if no start is accepted; DONE -> BUSY/DONE if back-to-back start is accepted.
  - Any state -> IDLE on flush=1.

- Latency:
  - Normal operation: BUSY in cycles 1..32, done=1 in cycle 33.
  - Trivial case: done=1 in cycle 1.

- stall:
  - stall = (accepted start in this cycle) OR busy.
  - stall is low in the DONE cycle, so the pipeline advances and EX/MEM captures result.
  - stall=0 whenever flush=1.

- Multiply:
  - Unsigned shift-add of the 32-bit magnitudes into a 64-bit product, one multiplier bit per cycle.
  - Signedness: MULH treats both operands as signed. MULHSU treats only op_a as signed. MULHU and MUL use unsigned magnitudes; MUL low bits are sign-independent.
  - On entry to DONE the 64-bit product is two's-complement negated if the sign flag is set.
  - MUL returns product[31:0]; the MULH variants return product[63:32].

- Divide:
  - Restoring shift-subtract, one quotient bit per cycle.
  - Sign flags:
    - Quotient is negated if the operand signs differ (DIV only).
    - Remainder takes the dividend sign (REM only).
  - Signed ops use magnitudes of both operands.

- Trivial cases (decided at acceptance, 1-cycle latency):
  - op_b=0: DIV/DIVU return 0xFFFFFFFF; REM/REMU return op_a.
  - DIV/REM with op_a=0x80000000 and op_b=0xFFFFFFFF: DIV returns 0x80000000, REM returns 0.

- Result hold:
  - result is registered and updated only on entry to DONE.
  - It holds its value afterwards until the next DONE.
  - It is not cleared by flush.
  - done is a 1-cycle pulse.

- Simultaneous events:
  - reset has priority over flush, and flush over start.
  - start and flush in the same cycle: the operation is not accepted.
  - flush in the DONE cycle: done is still 1 that cycle; the consumer gates it with its own flush.

Test Plan:
- MUL: op_a=7, op_b=0xFFFFFFFA (-6), start 1 cycle -> stall high for cycles 0..32; done=1 only in cycle 33; result=0xFFFFFFD6 (-42).
- MULH/MULHU/MULHSU with op_a=0x80000000, op_b=0xFFFFFFFF -> MULH 0x00000000, MULHU 0x7FFFFFFF, MULHSU 0x80000000; each with 33-cycle latency.
- DIV/REM: op_a=-7 (0xFFFFFFF9), op_b=2 -> DIV 0xFFFFFFFD (-3), REM 0xFFFFFFFF (-1); DIVU 0x7FFFFFFC; REMU 1.
- Trivial cases:
  - DIVU with op_b=0 -> done in cycle 1, result 0xFFFFFFFF.
  - REM with op_a=0x80000000, op_b=0xFFFFFFFF -> done in cycle 1, result 0.
  - stall high only in cycle 0.
- Flush at BUSY cycle 10 -> busy and stall drop the next cycle; no done; the next start (MUL 3*4) yields 12 after 33 cycles.
- start held high through BUSY with op_a/op_b changing -> no restart; result reflects cycle-0 operands.
- Back-to-back start in the DONE cycle -> second done 33 cycles later.
- reset asserted at BUSY cycle 5 -> next cycle: IDLE, stall=0, result=0.
